wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Writeback stage directly downstream of the execute ALU in the 4-thread barrel pipeline.
- Consumes the ALU's registered result (rd enable/address/data, thread id, next PC) and load results from the LSU.
- Arbitrates the single register-file write port and maintains the per-thread PC table.
- Maintains the per-thread register scoreboard that issue queries for RAW hazards.

Parameters:
XLEN, 32, data width
ADDR_LEN, 32, byte-address width; PCs are word addresses of ADDR_LEN-2 bits
THREADS, 4, hardware thread count (thread id width = $clog2(THREADS))
BUF_DEPTH, 2, ALU result FIFO entries
RESET_PC, 0, word-address PC loaded into every thread on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU outputs carry a real instruction this cycle
alu_ready  out  1  FIFO can accept; issue stalls when low
alu_rd_en  in  1  instruction writes rd
alu_rd_addr  in  5  rd (rs_addr_t)
alu_rd_data  in  XLEN  result
alu_thread  in  2  thread id
alu_new_pc  in  ADDR_LEN-2  next PC for alu_thread
lsu_valid  in  1  load result valid (cannot be stalled)
lsu_rd_addr  in  5  load destination
lsu_rd_data  in  XLEN  load data
lsu_thread  in  2  load thread id
rf_we  out  1  register-file write enable (registered)
rf_thread  out  2  write thread
rf_addr  out  5  write register
rf_data  out  XLEN  write data
pc_rd_thread  in  2  PC table read select
pc_rd_data  out  ADDR_LEN-2  PC of pc_rd_thread (combinational)
sb_set  in  1  issue marks a destination pending
sb_set_thread  in  2  thread for sb_set
sb_set_addr  in  5  register for sb_set
sb_q_thread  in  2  scoreboard query thread
sb_q_rs1  in  5  query register 1
sb_q_rs2  in  5  query register 2
sb_busy1  out  1  rs1 pending (combinational)
sb_busy2  out  1  rs2 pending (combinational)

Behaviour:
- Reset (sync, rst=1 at an edge):
  - FIFO emptied.
  - All scoreboard bits cleared.
  - Every PC = RESET_PC.
  - rf_we=0; rf_thread/rf_addr/rf_data=0.
  - alu_ready=1 in the cycle after reset.
  - Reset mid-operation discards FIFO contents and in-flight writes; no write follows reset.
- Accept: alu_valid && alu_ready at an edge.
  - PC table: pc[alu_thread] <= alu_new_pc on every accept, whether or not rd is written.
  - FIFO push only when alu_rd_en && alu_rd_addr != 0.
- alu_ready = (count < BUF_DEPTH), from registered count only. No same-cycle pop-to-push bypass on full.
  - alu_valid while alu_ready=0 is ignored: no push, no PC update. Upstream must hold.
- Write arbitration, evaluated each cycle, result registered:
  - LSU has absolute priority. lsu_valid && lsu_rd_addr != 0 → rf_* <= LSU fields and rf_we <= 1; FIFO head is held.
  - Otherwise, FIFO non-empty → rf_* <= head and the head is popped.
  - Otherwise rf_we <= 0.
  - lsu_valid with lsu_rd_addr == 0 writes nothing; the FIFO may drain that cycle.
- Latency, uncontended: ALU accepted at edge E → written to FIFO; rf_we=1 after edge E+1, i.e. 2 cycles input-to-write.
- Simultaneous push and pop: count unchanged; both legal, including when full (pop frees, but ready was already 0).
- FIFO pointers wrap modulo BUF_DEPTH. Count width is $clog2(BUF_DEPTH+1).
- Scoreboard: THREADS x 32 bits.
  - Set by sb_set when sb_set_addr != 0.
  - Cleared for (thread, addr) at the edge where a write is selected into rf_*. The bit is already clear when rf_we is visible.
  - Set and clear of the same bit at the same edge: set wins (newer instruction).
  - Register x0 is never busy.
  - Queries are combinational on current state; no bypass of a same-cycle set.
- PC write and pc_rd at the same thread: pc_rd_data shows the old value until the edge.

Decomposition:
- cpu_types gains wb_entry_t {thread, rd_addr, rd_data} and a thread_id_t typedef.
- cpu_config gains WB_BUF_DEPTH and RESET_PC.
- One sub-module, wb_fifo: parameterized sync FIFO of wb_entry_t with count output.
- Scoreboard and PC table stay inline.

Test Plan:
- Reset, then ALU accept thread 1, x5=0xDEADBEEF, new_pc=0x40 → 2 cycles later rf_we=1, rf_thread=1, rf_addr=5, rf_data=0xDEADBEEF; pc_rd(1)=0x40; PCs of threads 0, 2, 3 = RESET_PC.
- lsu_valid every cycle for 4 cycles while ALU issues 3 results → alu_ready drops after 2 pushes; LSU writes appear in order; ALU results then drain in FIFO order; no loss or duplication.
- ALU writes to x0, and ALU with rd_en=0 (branch) → no rf_we; PC still updated.
- sb_set thread 2 x7, later ALU writeback thread 2 x7 → sb_busy1 (q 2,x7) =1 until the write edge, then 0. Same-edge set+clear → remains 1.
- Query x0 after sb_set x0 → sb_busy=0.
- Assert rst with FIFO holding 2 entries and scoreboard bits set → next cycle rf_we=0, count=0, all busy=0, PCs=RESET_PC; no stale write afterward.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared types and configuration for the writeback stage of the 4-thread barrel pipeline.
// The FIFO entry layout and the default PC/buffer parameters live here.
package wb_unit_pkg;

    localparam int XLEN         = 32;
    localparam int ADDR_LEN     = 32;
    localparam int THREADS      = 4;
    localparam int WB_BUF_DEPTH = 2;
    localparam logic [ADDR_LEN-3:0] RESET_PC = '0;

    typedef logic [$clog2(THREADS)-1:0] thread_id_t;
    typedef logic [4:0]                 rs_addr_t;

    typedef struct packed {
        thread_id_t      thread;
        rs_addr_t        rd_addr;
        logic [XLEN-1:0] rd_data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of pending ALU writebacks; exposes the head entry and occupancy.
// The caller guarantees no push when full and no pop when empty.
module wb_fifo
    import wb_unit_pkg::*;
#(
    parameter int DEPTH = WB_BUF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  wb_entry_t     i_data,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates the register-file write port (LSU first, then buffered ALU
// results), keeps the per-thread PC table and the per-thread RAW scoreboard.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int                  XLEN      = wb_unit_pkg::XLEN,
    parameter int                  ADDR_LEN  = wb_unit_pkg::ADDR_LEN,
    parameter int                  THREADS   = wb_unit_pkg::THREADS,
    parameter int                  BUF_DEPTH = WB_BUF_DEPTH,
    parameter logic [ADDR_LEN-3:0] RESET_PC  = wb_unit_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic                alu_rd_en,
    input  logic [4:0]          alu_rd_addr,
    input  logic [XLEN-1:0]     alu_rd_data,
    input  logic [1:0]          alu_thread,
    input  logic [ADDR_LEN-3:0] alu_new_pc,
    input  logic                lsu_valid,
    input  logic [4:0]          lsu_rd_addr,
    input  logic [XLEN-1:0]     lsu_rd_data,
    input  logic [1:0]          lsu_thread,
    output logic                rf_we,
    output logic [1:0]          rf_thread,
    output logic [4:0]          rf_addr,
    output logic [XLEN-1:0]     rf_data,
    input  logic [1:0]          pc_rd_thread,
    output logic [ADDR_LEN-3:0] pc_rd_data,
    input  logic                sb_set,
    input  logic [1:0]          sb_set_thread,
    input  logic [4:0]          sb_set_addr,
    input  logic [1:0]          sb_q_thread,
    input  logic [4:0]          sb_q_rs1,
    input  logic [4:0]          sb_q_rs2,
    output logic                sb_busy1,
    output logic                sb_busy2
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0] w_count;
    logic          w_empty;
    wb_entry_t     w_head;
    wb_entry_t     w_push_data;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_lsu_wr;
    logic          w_clr_en;
    thread_id_t    w_clr_thread;
    rs_addr_t      w_clr_addr;

    logic                               r_rf_we;
    logic [1:0]                         r_rf_thread;
    logic [4:0]                         r_rf_addr;
    logic [XLEN-1:0]                    r_rf_data;
    logic [THREADS-1:0][ADDR_LEN-3:0]   r_pc;
    logic [THREADS-1:0][31:0]           r_sb;

    // Ready comes only from the registered count, so a full buffer stalls issue even on a pop cycle.
    assign alu_ready   = (w_count < CW'(BUF_DEPTH));
    assign w_accept    = alu_valid && alu_ready;
    assign w_push      = w_accept && alu_rd_en && (alu_rd_addr != 5'd0);
    assign w_lsu_wr    = lsu_valid && (lsu_rd_addr != 5'd0);
    assign w_pop       = !w_lsu_wr && !w_empty;
    assign w_push_data = '{thread: alu_thread, rd_addr: alu_rd_addr, rd_data: alu_rd_data};

    wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we     <= 1'b0;
            r_rf_thread <= '0;
            r_rf_addr   <= '0;
            r_rf_data   <= '0;
        end else if (w_lsu_wr) begin
            r_rf_we     <= 1'b1;
            r_rf_thread <= lsu_thread;
            r_rf_addr   <= lsu_rd_addr;
            r_rf_data   <= lsu_rd_data;
        end else if (w_pop) begin
            r_rf_we     <= 1'b1;
            r_rf_thread <= w_head.thread;
            r_rf_addr   <= w_head.rd_addr;
            r_rf_data   <= w_head.rd_data;
        end else begin
            r_rf_we     <= 1'b0;
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_thread = r_rf_thread;
    assign rf_addr   = r_rf_addr;
    assign rf_data   = r_rf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < THREADS; i++) r_pc[i] <= RESET_PC;
        end else if (w_accept) begin
            r_pc[alu_thread] <= alu_new_pc;
        end
    end

    assign pc_rd_data = r_pc[pc_rd_thread];

    assign w_clr_en     = w_lsu_wr || w_pop;
    assign w_clr_thread = w_lsu_wr ? lsu_thread  : w_head.thread;
    assign w_clr_addr   = w_lsu_wr ? lsu_rd_addr : w_head.rd_addr;

    // The set is written after the clear so a newer instruction's claim survives the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            if (w_clr_en) r_sb[w_clr_thread][w_clr_addr] <= 1'b0;
            if (sb_set && (sb_set_addr != 5'd0)) r_sb[sb_set_thread][sb_set_addr] <= 1'b1;
        end
    end

    assign sb_busy1 = (sb_q_rs1 != 5'd0) && r_sb[sb_q_thread][sb_q_rs1];
    assign sb_busy2 = (sb_q_rs2 != 5'd0) && r_sb[sb_q_thread][sb_q_rs2];

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: reset, latency, LSU priority and FIFO drain, no-write cases,
// scoreboard set/clear ordering and mid-operation reset. Inputs change and outputs are sampled on negedge.
module tb_wb_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic        alu_rd_en;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_data;
    logic [1:0]  alu_thread;
    logic [29:0] alu_new_pc;
    logic        lsu_valid;
    logic [4:0]  lsu_rd_addr;
    logic [31:0] lsu_rd_data;
    logic [1:0]  lsu_thread;
    logic        rf_we;
    logic [1:0]  rf_thread;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  pc_rd_thread;
    logic [29:0] pc_rd_data;
    logic        sb_set;
    logic [1:0]  sb_set_thread;
    logic [4:0]  sb_set_addr;
    logic [1:0]  sb_q_thread;
    logic [4:0]  sb_q_rs1;
    logic [4:0]  sb_q_rs2;
    logic        sb_busy1;
    logic        sb_busy2;

    int vectors;
    int miscompares;

    wb_unit dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd_en     (alu_rd_en),
        .alu_rd_addr   (alu_rd_addr),
        .alu_rd_data   (alu_rd_data),
        .alu_thread    (alu_thread),
        .alu_new_pc    (alu_new_pc),
        .lsu_valid     (lsu_valid),
        .lsu_rd_addr   (lsu_rd_addr),
        .lsu_rd_data   (lsu_rd_data),
        .lsu_thread    (lsu_thread),
        .rf_we         (rf_we),
        .rf_thread     (rf_thread),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .pc_rd_thread  (pc_rd_thread),
        .pc_rd_data    (pc_rd_data),
        .sb_set        (sb_set),
        .sb_set_thread (sb_set_thread),
        .sb_set_addr   (sb_set_addr),
        .sb_q_thread   (sb_q_thread),
        .sb_q_rs1      (sb_q_rs1),
        .sb_q_rs2      (sb_q_rs2),
        .sb_busy1      (sb_busy1),
        .sb_busy2      (sb_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_alu(input logic [1:0] t, input logic en, input logic [4:0] a,
                             input logic [31:0] d, input logic [29:0] pc);
        alu_valid = 1'b1; alu_thread = t; alu_rd_en = en;
        alu_rd_addr = a; alu_rd_data = d; alu_new_pc = pc;
    endtask

    task automatic drive_lsu(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_thread = t; lsu_rd_addr = a; lsu_rd_data = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q_thread = 2'd0; sb_q_rs1 = 5'd1; sb_q_rs2 = 5'd2;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_thread !== 2'd0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rf: got we=%b t=%0d a=%0d d=%h, want 0/0/0/0", rf_we, rf_thread, rf_addr, rf_data);
        end
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b want 1", alu_ready);
        end
        vectors++;
        if (sb_busy1 !== 1'b0 || sb_busy2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b%b want 00", sb_busy1, sb_busy2);
        end
        for (int t = 0; t < 4; t++) begin
            pc_rd_thread = 2'(t);
            #1;
            vectors++;
            if (pc_rd_data !== 30'd0) begin
                miscompares++; $display("FAIL reset_pc%0d: got %h want 0", t, pc_rd_data);
            end
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        drive_alu(2'd1, 1'b1, 5'd5, 32'hDEADBEEF, 30'h40);
        pc_rd_thread = 2'd1;
        #1;
        vectors++;
        if (pc_rd_data !== 30'd0) begin
            miscompares++; $display("FAIL basic_pc_old: got %h want 0", pc_rd_data);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++; $display("FAIL basic_latency1: rf_we got %b want 0", rf_we);
        end
        vectors++;
        if (pc_rd_data !== 30'h40) begin
            miscompares++; $display("FAIL basic_pc_new: got %h want 40", pc_rd_data);
        end
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_thread !== 2'd1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_write: got we=%b t=%0d a=%0d d=%h, want 1/1/5/deadbeef", rf_we, rf_thread, rf_addr, rf_data);
        end
        for (int t = 0; t < 4; t++) begin
            if (t == 1) continue;
            pc_rd_thread = 2'(t);
            #1;
            vectors++;
            if (pc_rd_data !== 30'd0) begin
                miscompares++; $display("FAIL basic_pc%0d: got %h want 0", t, pc_rd_data);
            end
        end
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++; $display("FAIL basic_idle: rf_we got %b want 0", rf_we);
        end
    endtask

    // LSU owns four consecutive cycles while three ALU results queue up behind it.
    task automatic test_lsu_priority;
        logic        exp_we    [1:8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [4:0]  exp_addr  [1:8] = '{10, 11, 12, 13, 1, 2, 3, 0};
        logic [31:0] exp_data  [1:8] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hA0, 32'hA1, 32'hA2, 0};
        logic [1:0]  exp_thr   [1:8] = '{0, 1, 2, 3, 0, 1, 2, 0};
        logic        exp_ready [1:8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        pc_rd_thread = 2'd2;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                #1;
                vectors++;
                if (rf_we !== exp_we[k] ||
                    (exp_we[k] && (rf_addr !== exp_addr[k] || rf_data !== exp_data[k] || rf_thread !== exp_thr[k]))) begin
                    miscompares++;
                    $display("FAIL prio_cyc%0d: got we=%b t=%0d a=%0d d=%h, want %b/%0d/%0d/%h",
                             k, rf_we, rf_thread, rf_addr, rf_data, exp_we[k], exp_thr[k], exp_addr[k], exp_data[k]);
                end
                vectors++;
                if (alu_ready !== exp_ready[k]) begin
                    miscompares++; $display("FAIL prio_ready%0d: got %b want %b", k, alu_ready, exp_ready[k]);
                end
            end
            if (k == 4) begin
                vectors++;
                if (pc_rd_data !== 30'd0) begin
                    miscompares++; $display("FAIL prio_stalled_pc: got %h want 0", pc_rd_data);
                end
            end
            if (k < 4) drive_lsu(2'(k), 5'(10 + k), 32'h100 + 32'(k));
            else       lsu_valid = 1'b0;
            if (k < 6) begin
                int a;
                a = (k < 2) ? k : 2;
                drive_alu(2'(a), 1'b1, 5'(1 + a), 32'hA0 + 32'(a), 30'h10 + 30'(a));
            end else begin
                alu_valid = 1'b0;
            end
        end
        for (int t = 0; t < 3; t++) begin
            pc_rd_thread = 2'(t);
            #1;
            vectors++;
            if (pc_rd_data !== 30'h10 + 30'(t)) begin
                miscompares++; $display("FAIL prio_pc%0d: got %h want %h", t, pc_rd_data, 30'h10 + 30'(t));
            end
        end
    endtask

    task automatic test_no_write;
        @(negedge clk);
        drive_alu(2'd3, 1'b1, 5'd0, 32'h55, 30'h77);
        @(negedge clk);
        drive_alu(2'd0, 1'b0, 5'd9, 32'h66, 30'h88);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            alu_valid = 1'b0;
            #1;
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++; $display("FAIL nowrite_cyc%0d: rf_we got %b want 0", k, rf_we);
            end
        end
        pc_rd_thread = 2'd3;
        #1;
        vectors++;
        if (pc_rd_data !== 30'h77) begin
            miscompares++; $display("FAIL nowrite_pc3: got %h want 77", pc_rd_data);
        end
        pc_rd_thread = 2'd0;
        #1;
        vectors++;
        if (pc_rd_data !== 30'h88) begin
            miscompares++; $display("FAIL nowrite_pc0: got %h want 88", pc_rd_data);
        end
        // An LSU result aimed at x0 must not block the FIFO from draining.
        @(negedge clk);
        drive_alu(2'd0, 1'b1, 5'd3, 32'h33, 30'h90);
        @(negedge clk);
        alu_valid = 1'b0;
        drive_lsu(2'd1, 5'd0, 32'hBAD);
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h33) begin
            miscompares++; $display("FAIL nowrite_lsu_x0: got we=%b a=%0d d=%h, want 1/3/33", rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_scoreboard;
        @(negedge clk);
        sb_set = 1'b1; sb_set_thread = 2'd2; sb_set_addr = 5'd7;
        sb_q_thread = 2'd2; sb_q_rs1 = 5'd7; sb_q_rs2 = 5'd0;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL sb_no_bypass: got %b want 0", sb_busy1);
        end
        @(negedge clk);
        sb_set = 1'b0;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b1 || sb_busy2 !== 1'b0) begin
            miscompares++; $display("FAIL sb_set: got %b%b want 10", sb_busy1, sb_busy2);
        end
        sb_q_thread = 2'd1;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL sb_other_thread: got %b want 0", sb_busy1);
        end
        sb_q_thread = 2'd2;
        drive_alu(2'd2, 1'b1, 5'd7, 32'h77, 30'h20);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_pending: got %b want 1", sb_busy1);
        end
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_thread !== 2'd2 || sb_busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_clear: got we=%b t=%0d a=%0d busy=%b, want 1/2/7/0", rf_we, rf_thread, rf_addr, sb_busy1);
        end
        // Re-issue to x7 lands on the same edge the earlier write clears it.
        sb_set = 1'b1;
        @(negedge clk);
        sb_set = 1'b0;
        drive_alu(2'd2, 1'b1, 5'd7, 32'h78, 30'h21);
        @(negedge clk);
        alu_valid = 1'b0;
        sb_set = 1'b1;
        @(negedge clk);
        sb_set = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_data !== 32'h78 || sb_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_set_wins: got we=%b d=%h busy=%b, want 1/78/1", rf_we, rf_data, sb_busy1);
        end
        sb_set = 1'b1; sb_set_thread = 2'd0; sb_set_addr = 5'd0;
        @(negedge clk);
        sb_set = 1'b0;
        sb_q_thread = 2'd0; sb_q_rs1 = 5'd0; sb_q_rs2 = 5'd0;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b0 || sb_busy2 !== 1'b0) begin
            miscompares++; $display("FAIL sb_x0: got %b%b want 00", sb_busy1, sb_busy2);
        end
        sb_set = 1'b1; sb_set_thread = 2'd1; sb_set_addr = 5'd4;
        @(negedge clk);
        sb_set = 1'b0;
        drive_lsu(2'd1, 5'd4, 32'h44);
        sb_q_thread = 2'd1; sb_q_rs2 = 5'd4;
        #1;
        vectors++;
        if (sb_busy2 !== 1'b1) begin
            miscompares++; $display("FAIL sb_lsu_pending: got %b want 1", sb_busy2);
        end
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        vectors++;
        if (sb_busy2 !== 1'b0 || rf_we !== 1'b1 || rf_data !== 32'h44) begin
            miscompares++; $display("FAIL sb_lsu_clear: got busy=%b we=%b d=%h, want 0/1/44", sb_busy2, rf_we, rf_data);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive_lsu(2'd0, 5'd20, 32'h200);
        drive_alu(2'd1, 1'b1, 5'd21, 32'h210, 30'h50);
        sb_set = 1'b1; sb_set_thread = 2'd3; sb_set_addr = 5'd9;
        @(negedge clk);
        sb_set = 1'b0;
        drive_alu(2'd2, 1'b1, 5'd22, 32'h220, 30'h60);
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rst = 1'b1;
        sb_q_thread = 2'd3; sb_q_rs1 = 5'd9;
        #1;
        vectors++;
        if (alu_ready !== 1'b0 || sb_busy1 !== 1'b1) begin
            miscompares++; $display("FAIL rmid_pre: got ready=%b busy=%b, want 0/1", alu_ready, sb_busy1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0 || rf_thread !== 2'd0) begin
            miscompares++;
            $display("FAIL rmid_rf: got we=%b t=%0d a=%0d d=%h, want 0/0/0/0", rf_we, rf_thread, rf_addr, rf_data);
        end
        vectors++;
        if (alu_ready !== 1'b1 || sb_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL rmid_state: got ready=%b busy=%b, want 1/0", alu_ready, sb_busy1);
        end
        sb_q_thread = 2'd2; sb_q_rs1 = 5'd7;
        #1;
        vectors++;
        if (sb_busy1 !== 1'b0) begin
            miscompares++; $display("FAIL rmid_sb_t2x7: got %b want 0", sb_busy1);
        end
        for (int t = 0; t < 4; t++) begin
            pc_rd_thread = 2'(t);
            #1;
            vectors++;
            if (pc_rd_data !== 30'd0) begin
                miscompares++; $display("FAIL rmid_pc%0d: got %h want 0", t, pc_rd_data);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++; $display("FAIL rmid_stale%0d: rf_we got %b want 0", k, rf_we);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd_en = 1'b0; alu_rd_addr = '0; alu_rd_data = '0;
        alu_thread = '0; alu_new_pc = '0;
        lsu_valid = 1'b0; lsu_rd_addr = '0; lsu_rd_data = '0; lsu_thread = '0;
        pc_rd_thread = '0;
        sb_set = 1'b0; sb_set_thread = '0; sb_set_addr = '0;
        sb_q_thread = '0; sb_q_rs1 = '0; sb_q_rs2 = '0;
        test_reset;
        test_basic;
        test_lsu_priority;
        test_no_write;
        test_scoreboard;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
